// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: LSB-first frames into WIDTH-bit words on a valid/ready handshake.
// Optional even-parity framing (one trailing parity bit per word) is enabled by defining SIPO_PARITY_EN.
module sipo_deserializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             shift_en,
  input  logic             clr_overrun,
  input  logic             ready,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_count,
  output logic             parity_err
);

`ifdef SIPO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
  // Holds all WIDTH data bits; the parity bit is only looked at, never stored.
  localparam int SR_W      = WIDTH;
`else
  localparam int FRAME_LEN = WIDTH;
  // The last data bit goes straight from serial_in into the word, so one bit less is kept.
  localparam int SR_W      = WIDTH - 1;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  logic [SR_W-1:0]  shift_q, shift_d, shift_next;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic [WIDTH-1:0] data_q, data_d, new_word;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_done, data_shift, new_perr;

  generate
    if (SR_W == 1) begin : g_sr_single
      assign shift_next = serial_in;
    end else begin : g_sr_multi
      assign shift_next = {serial_in, shift_q[SR_W-1:1]};
    end
  endgenerate

  assign frame_done = shift_en && (bit_count_q == LAST_CNT);

`ifdef SIPO_PARITY_EN
  assign data_shift = shift_en && !frame_done;
  assign new_word   = shift_q;
  assign new_perr   = (^shift_q) ^ serial_in;
`else
  assign data_shift = shift_en;
  assign new_word   = {serial_in, shift_q};
  assign new_perr   = 1'b0;
`endif

  always_comb begin
    shift_d      = shift_q;
    bit_count_d  = bit_count_q;
    data_d       = data_q;
    valid_d      = valid_q;
    overrun_d    = clr_overrun ? 1'b0 : overrun_q;
    parity_err_d = parity_err_q;

    if (data_shift) shift_d = shift_next;
    if (shift_en) bit_count_d = frame_done ? '0 : bit_count_q + 1'b1;

    if (valid_q && ready) valid_d = 1'b0;

    // A completing frame either loads (slot free or being consumed now) or is dropped.
    if (frame_done) begin
      if (!valid_q || ready) begin
        data_d       = new_word;
        valid_d      = 1'b1;
        parity_err_d = new_perr;
      end else begin
        overrun_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q      <= '0;
      bit_count_q  <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      bit_count_q  <= bit_count_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign overrun    = overrun_q;
  assign bit_count  = bit_count_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: directed frame table, hand-written corner sequences,
// and randomized traffic against a frame-level reference model.
module tb_sipo_deserializer;
  localparam int WIDTH = 8;
  localparam int CNT_W = 5;
`ifdef SIPO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             serial_in = 1'b0;
  logic             shift_en = 1'b0;
  logic             clr_overrun = 1'b0;
  logic             ready = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             overrun;
  logic [CNT_W-1:0] bit_count;
  logic             parity_err;

  int checks = 0;
  int failures = 0;

  // Reference model state: bits collected so far in the frame, and the expected outputs.
  int               m_cnt = 0;
  logic [WIDTH-1:0] m_word = '0;
  logic             m_par = 1'b0;
  logic [WIDTH-1:0] e_data = '0;
  logic             e_valid = 1'b0;
  logic             e_ovr = 1'b0;
  logic             e_perr = 1'b0;

  typedef struct {
    logic [7:0] word;
    bit         rdy;
    bit         rdy_last;
    bit         clr;
    logic [7:0] exp_data;
    bit         exp_valid;
    bit         exp_ovr;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .shift_en(shift_en),
    .clr_overrun(clr_overrun), .ready(ready), .data_out(data_out), .valid(valid),
    .overrun(overrun), .bit_count(bit_count), .parity_err(parity_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    e_data  = '0;
    e_valid = 1'b0;
    e_ovr   = 1'b0;
    e_perr  = 1'b0;
  endtask

  task automatic model_edge(input bit se, input bit si, input bit rdy, input bit clr);
    bit   done;
    logic nov;
    done = 1'b0;
    nov  = clr ? 1'b0 : e_ovr;
    if (se) begin
      if (m_cnt < WIDTH) m_word[m_cnt] = si;
      else m_par = si;
      m_cnt++;
      if (m_cnt == FRAME_LEN) begin
        done  = 1'b1;
        m_cnt = 0;
      end
    end
    if (done) begin
      if (!e_valid || rdy) begin
        e_data  = m_word;
        e_valid = 1'b1;
`ifdef SIPO_PARITY_EN
        e_perr  = (^m_word) ^ m_par;
`endif
        $display("frame loaded  word=%h ready=%0b", m_word, rdy);
      end else begin
        nov = 1'b1;
        $display("frame dropped word=%h (held %h)", m_word, e_data);
      end
    end else if (e_valid && rdy) begin
      e_valid = 1'b0;
    end
    e_ovr = nov;
  endtask

  task automatic check_all();
    chk("data_out",   32'(data_out),   32'(e_data));
    chk("valid",      32'(valid),      32'(e_valid));
    chk("overrun",    32'(overrun),    32'(e_ovr));
    chk("bit_count",  32'(bit_count),  32'(m_cnt));
    chk("parity_err", 32'(parity_err), 32'(e_perr));
  endtask

  task automatic step(input bit rs, input bit se, input bit si, input bit rdy, input bit clr);
    @(negedge clk);
    reset = rs; shift_en = se; serial_in = si; ready = rdy; clr_overrun = clr;
    @(posedge clk);
    if (rs) model_reset();
    else model_edge(se, si, rdy, clr);
    #1;
    check_all();
  endtask

  // Sends one frame; ready is rdy on every edge except the completing one (rdy_last).
  task automatic send_frame(input logic [7:0] w, input bit rdy, input bit rdy_last,
                            input bit clr, input bit par_flip);
    logic [7:0] wv;
    wv = w;
    for (int i = 0; i < FRAME_LEN; i++) begin
      step(1'b0, 1'b1, (i < WIDTH) ? wv[i] : ((^wv) ^ par_flip),
           (i == FRAME_LEN - 1) ? rdy_last : rdy, clr);
    end
  endtask

  initial begin
    logic [7:0] g;
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1};
    vecs[4] = '{8'h81, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1};
    vecs[5] = '{8'h4D, 1'b1, 1'b1, 1'b1, 8'h4D, 1'b1, 1'b0};
    vecs[6] = '{8'hC3, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0};

    // Reset held while shifting toggling data: everything stays zero.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, i[0], 1'b1, 1'b0);
      chk("rst_bit_count", 32'(bit_count), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("count_after_release", 32'(bit_count), 32'd1);

    // 8'h4D held without ready, then one ready pulse.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h4D, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("4d_data", 32'(data_out), 32'h4D);
    chk("4d_valid", 32'(valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("4d_hold_data", 32'(data_out), 32'h4D);
      chk("4d_hold_valid", 32'(valid), 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("4d_consumed_valid", 32'(valid), 32'd0);
    chk("4d_consumed_data", 32'(data_out), 32'h4D);

    // Frame table from a clean reset.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].word, vecs[v].rdy, vecs[v].rdy_last, vecs[v].clr, 1'b0);
      chk("tbl_data", 32'(data_out), 32'(vecs[v].exp_data));
      chk("tbl_valid", 32'(valid), 32'(vecs[v].exp_valid));
      chk("tbl_overrun", 32'(overrun), 32'(vecs[v].exp_ovr));
    end

    // 8'h81 with two idle cycles between every bit.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    g = 8'h81;
    for (int i = 0; i < FRAME_LEN; i++) begin
      step(1'b0, 1'b1, (i < WIDTH) ? g[i] : ^g, 1'b0, 1'b0);
      if (i < FRAME_LEN - 1) begin
        for (int k = 0; k < 2; k++) begin
          step(1'b0, 1'b0, ~serial_in, 1'b0, 1'b0);
          chk("gap_bit_count", 32'(bit_count), 32'(i + 1));
        end
      end
    end
    chk("gap_data", 32'(data_out), 32'h81);
    chk("gap_valid", 32'(valid), 32'd1);

`ifdef SIPO_PARITY_EN
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h4D, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("par_ok_data", 32'(data_out), 32'h4D);
    chk("par_ok_err", 32'(parity_err), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h4D, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("par_bad_data", 32'(data_out), 32'h4D);
    chk("par_bad_err", 32'(parity_err), 32'd1);
`endif

    // Asynchronous reset part-way through a frame.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_bit_count", 32'(bit_count), 32'd0);
    chk("async_valid", 32'(valid), 32'd0);
    chk("async_data", 32'(data_out), 32'd0);
    model_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("async_c3_data", 32'(data_out), 32'hC3);
    chk("async_c3_valid", 32'(valid), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           1'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
